// File: rtl/sm4_pkg.sv
// Shared SM4 constants: the tau S-box table, its lookup function, and the
// FK/CK key-schedule constants used by the key-expansion and round blocks.
package sm4_pkg;

  // SBOX[{row, col}] with row = byte[7:4], col = byte[3:0]
  localparam logic [7:0] SBOX [256] = '{
    8'hD6, 8'h90, 8'hE9, 8'hFE, 8'hCC, 8'hE1, 8'h3D, 8'hB7, 8'h16, 8'hB6, 8'h14, 8'hC2, 8'h28, 8'hFB, 8'h2C, 8'h05,
    8'h2B, 8'h67, 8'h9A, 8'h76, 8'h2A, 8'hBE, 8'h04, 8'hC3, 8'hAA, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9C, 8'h42, 8'h50, 8'hF4, 8'h91, 8'hEF, 8'h98, 8'h7A, 8'h33, 8'h54, 8'h0B, 8'h43, 8'hED, 8'hCF, 8'hAC, 8'h62,
    8'hE4, 8'hB3, 8'h1C, 8'hA9, 8'hC9, 8'h08, 8'hE8, 8'h95, 8'h80, 8'hDF, 8'h94, 8'hFA, 8'h75, 8'h8F, 8'h3F, 8'hA6,
    8'h47, 8'h07, 8'hA7, 8'hFC, 8'hF3, 8'h73, 8'h17, 8'hBA, 8'h83, 8'h59, 8'h3C, 8'h19, 8'hE6, 8'h85, 8'h4F, 8'hA8,
    8'h68, 8'h6B, 8'h81, 8'hB2, 8'h71, 8'h64, 8'hDA, 8'h8B, 8'hF8, 8'hEB, 8'h0F, 8'h4B, 8'h70, 8'h56, 8'h9D, 8'h35,
    8'h1E, 8'h24, 8'h0E, 8'h5E, 8'h63, 8'h58, 8'hD1, 8'hA2, 8'h25, 8'h22, 8'h7C, 8'h3B, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hD4, 8'h00, 8'h46, 8'h57, 8'h9F, 8'hD3, 8'h27, 8'h52, 8'h4C, 8'h36, 8'h02, 8'hE7, 8'hA0, 8'hC4, 8'hC8, 8'h9E,
    8'hEA, 8'hBF, 8'h8A, 8'hD2, 8'h40, 8'hC7, 8'h38, 8'hB5, 8'hA3, 8'hF7, 8'hF2, 8'hCE, 8'hF9, 8'h61, 8'h15, 8'hA1,
    8'hE0, 8'hAE, 8'h5D, 8'hA4, 8'h9B, 8'h34, 8'h1A, 8'h55, 8'hAD, 8'h93, 8'h32, 8'h30, 8'hF5, 8'h8C, 8'hB1, 8'hE3,
    8'h1D, 8'hF6, 8'hE2, 8'h2E, 8'h82, 8'h66, 8'hCA, 8'h60, 8'hC0, 8'h29, 8'h23, 8'hAB, 8'h0D, 8'h53, 8'h4E, 8'h6F,
    8'hD5, 8'hDB, 8'h37, 8'h45, 8'hDE, 8'hFD, 8'h8E, 8'h2F, 8'h03, 8'hFF, 8'h6A, 8'h72, 8'h6D, 8'h6C, 8'h5B, 8'h51,
    8'h8D, 8'h1B, 8'hAF, 8'h92, 8'hBB, 8'hDD, 8'hBC, 8'h7F, 8'h11, 8'hD9, 8'h5C, 8'h41, 8'h1F, 8'h10, 8'h5A, 8'hD8,
    8'h0A, 8'hC1, 8'h31, 8'h88, 8'hA5, 8'hCD, 8'h7B, 8'hBD, 8'h2D, 8'h74, 8'hD0, 8'h12, 8'hB8, 8'hE5, 8'hB4, 8'hB0,
    8'h89, 8'h69, 8'h97, 8'h4A, 8'h0C, 8'h96, 8'h77, 8'h7E, 8'h65, 8'hB9, 8'hF1, 8'h09, 8'hC5, 8'h6E, 8'hC6, 8'h84,
    8'h18, 8'hF0, 8'h7D, 8'hEC, 8'h3A, 8'hDC, 8'h4D, 8'h20, 8'h79, 8'hEE, 8'h5F, 8'h3E, 8'hD7, 8'hCB, 8'h39, 8'h48
  };

  localparam logic [31:0] FK [4] = '{
    32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC
  };

  // CK[i] byte j = (4*i + j) * 7 mod 256
  localparam logic [31:0] CK [32] = '{
    32'h00070E15, 32'h1C232A31, 32'h383F464D, 32'h545B6269,
    32'h70777E85, 32'h8C939AA1, 32'hA8AFB6BD, 32'hC4CBD2D9,
    32'hE0E7EEF5, 32'hFC030A11, 32'h181F262D, 32'h343B4249,
    32'h50575E65, 32'h6C737A81, 32'h888F969D, 32'hA4ABB2B9,
    32'hC0C7CED5, 32'hDCE3EAF1, 32'hF8FF060D, 32'h141B2229,
    32'h30373E45, 32'h4C535A61, 32'h686F767D, 32'h848B9299,
    32'hA0A7AEB5, 32'hBCC3CAD1, 32'hD8DFE6ED, 32'hF4FB0209,
    32'h10171E25, 32'h2C333A41, 32'h484F565D, 32'h646B7279
  };

  function automatic logic [7:0] sm4_sbox_f(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/sm4_sbox.sv
// Registered one-byte SM4 S-box: combinational table lookup straight from the
// input pins into the output register, with the valid flag delayed alongside.
module sm4_sbox
  import sm4_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic [7:0] o_s_data,
  output logic       o_s_valid
);

  logic [7:0] s_data_d, s_data_q;
  logic       s_valid_d, s_valid_q;

  always_comb begin
    s_data_d  = sm4_sbox_f(i_data);
    s_valid_d = i_valid;
  end

  // Data loads every edge; consumers qualify it with o_s_valid.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s_data_q  <= 8'h00;
      s_valid_q <= 1'b0;
    end else begin
      s_data_q  <= s_data_d;
      s_valid_q <= s_valid_d;
    end
  end

  assign o_s_data  = s_data_q;
  assign o_s_valid = s_valid_q;

endmodule

// File: tb/tb_sm4_sbox.sv
// Bench for sm4_sbox: golden-table model checked every cycle, directed lookups,
// full sweep with permutation check, valid gating, async reset and 4-lane tau.
module tb_sm4_sbox;

  localparam logic [7:0] GOLD [256] = '{
    8'hD6, 8'h90, 8'hE9, 8'hFE, 8'hCC, 8'hE1, 8'h3D, 8'hB7, 8'h16, 8'hB6, 8'h14, 8'hC2, 8'h28, 8'hFB, 8'h2C, 8'h05,
    8'h2B, 8'h67, 8'h9A, 8'h76, 8'h2A, 8'hBE, 8'h04, 8'hC3, 8'hAA, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9C, 8'h42, 8'h50, 8'hF4, 8'h91, 8'hEF, 8'h98, 8'h7A, 8'h33, 8'h54, 8'h0B, 8'h43, 8'hED, 8'hCF, 8'hAC, 8'h62,
    8'hE4, 8'hB3, 8'h1C, 8'hA9, 8'hC9, 8'h08, 8'hE8, 8'h95, 8'h80, 8'hDF, 8'h94, 8'hFA, 8'h75, 8'h8F, 8'h3F, 8'hA6,
    8'h47, 8'h07, 8'hA7, 8'hFC, 8'hF3, 8'h73, 8'h17, 8'hBA, 8'h83, 8'h59, 8'h3C, 8'h19, 8'hE6, 8'h85, 8'h4F, 8'hA8,
    8'h68, 8'h6B, 8'h81, 8'hB2, 8'h71, 8'h64, 8'hDA, 8'h8B, 8'hF8, 8'hEB, 8'h0F, 8'h4B, 8'h70, 8'h56, 8'h9D, 8'h35,
    8'h1E, 8'h24, 8'h0E, 8'h5E, 8'h63, 8'h58, 8'hD1, 8'hA2, 8'h25, 8'h22, 8'h7C, 8'h3B, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hD4, 8'h00, 8'h46, 8'h57, 8'h9F, 8'hD3, 8'h27, 8'h52, 8'h4C, 8'h36, 8'h02, 8'hE7, 8'hA0, 8'hC4, 8'hC8, 8'h9E,
    8'hEA, 8'hBF, 8'h8A, 8'hD2, 8'h40, 8'hC7, 8'h38, 8'hB5, 8'hA3, 8'hF7, 8'hF2, 8'hCE, 8'hF9, 8'h61, 8'h15, 8'hA1,
    8'hE0, 8'hAE, 8'h5D, 8'hA4, 8'h9B, 8'h34, 8'h1A, 8'h55, 8'hAD, 8'h93, 8'h32, 8'h30, 8'hF5, 8'h8C, 8'hB1, 8'hE3,
    8'h1D, 8'hF6, 8'hE2, 8'h2E, 8'h82, 8'h66, 8'hCA, 8'h60, 8'hC0, 8'h29, 8'h23, 8'hAB, 8'h0D, 8'h53, 8'h4E, 8'h6F,
    8'hD5, 8'hDB, 8'h37, 8'h45, 8'hDE, 8'hFD, 8'h8E, 8'h2F, 8'h03, 8'hFF, 8'h6A, 8'h72, 8'h6D, 8'h6C, 8'h5B, 8'h51,
    8'h8D, 8'h1B, 8'hAF, 8'h92, 8'hBB, 8'hDD, 8'hBC, 8'h7F, 8'h11, 8'hD9, 8'h5C, 8'h41, 8'h1F, 8'h10, 8'h5A, 8'hD8,
    8'h0A, 8'hC1, 8'h31, 8'h88, 8'hA5, 8'hCD, 8'h7B, 8'hBD, 8'h2D, 8'h74, 8'hD0, 8'h12, 8'hB8, 8'hE5, 8'hB4, 8'hB0,
    8'h89, 8'h69, 8'h97, 8'h4A, 8'h0C, 8'h96, 8'h77, 8'h7E, 8'h65, 8'hB9, 8'hF1, 8'h09, 8'hC5, 8'h6E, 8'hC6, 8'h84,
    8'h18, 8'hF0, 8'h7D, 8'hEC, 8'h3A, 8'hDC, 8'h4D, 8'h20, 8'h79, 8'hEE, 8'h5F, 8'h3E, 8'hD7, 8'hCB, 8'h39, 8'h48
  };

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic        valid_in;
  logic [7:0]  s_data;
  logic        s_valid;
  logic [31:0] tau_in;
  logic        tau_vld_in;
  logic [31:0] tau_out;
  logic [3:0]  tau_vld_out;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sm4_sbox dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_data    (data_in),
    .i_valid   (valid_in),
    .o_s_data  (s_data),
    .o_s_valid (s_valid)
  );

  for (genvar l = 0; l < 4; l++) begin : g_tau
    sm4_sbox u_lane (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_data    (tau_in[8*l +: 8]),
      .i_valid   (tau_vld_in),
      .o_s_data  (tau_out[8*l +: 8]),
      .o_s_valid (tau_vld_out[l])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  // Model: whatever byte/valid was on the pins at the last edge, looked up in the golden table.
  logic [7:0] m_data;
  logic       m_valid;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data  <= 8'h00;
      m_valid <= 1'b0;
    end else begin
      m_data  <= GOLD[data_in];
      m_valid <= valid_in;
    end
  end

  always @(negedge clk) begin
    check("cyc_data", {24'd0, s_data}, {24'd0, m_data});
    check("cyc_valid", {31'd0, s_valid}, {31'd0, m_valid});
  end

  task automatic step(input logic [7:0] d, input logic v);
    data_in  = d;
    valid_in = v;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] anchor_in  [10] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h0F, 8'h10, 8'h11, 8'hF0, 8'hFE, 8'hFF};
  logic [7:0] anchor_exp [10] = '{8'hD6, 8'h90, 8'hE9, 8'hFE, 8'h05, 8'h2B, 8'h67, 8'h18, 8'h39, 8'h48};
  logic       vpat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  bit         seen [256];
  int         distinct;

  initial begin
    rst        = 1'b1;
    data_in    = 8'h00;
    valid_in   = 1'b0;
    tau_in     = 32'h0;
    tau_vld_in = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) step(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    check("rst_data", {24'd0, s_data}, 32'h0);
    check("rst_valid", {31'd0, s_valid}, 32'h0);
    rst = 1'b0;

    // Anchor lookups pin the golden table as well as the DUT
    for (int i = 0; i < 10; i++) begin
      step(anchor_in[i], 1'b1);
      check("anchor_data", {24'd0, s_data}, {24'd0, anchor_exp[i]});
      check("anchor_model", {24'd0, GOLD[anchor_in[i]]}, {24'd0, anchor_exp[i]});
      check("anchor_valid", {31'd0, s_valid}, 32'd1);
    end

    // Back-to-back sweep; results must form a permutation
    for (int i = 0; i < 256; i++) begin
      step(8'(i), 1'b1);
      seen[s_data] = 1'b1;
    end
    distinct = 0;
    for (int i = 0; i < 256; i++) if (seen[i]) distinct++;
    check("sweep_perm", distinct, 32'd256);

    // Valid gating: data still updates on invalid cycles
    for (int k = 0; k < 5; k++) begin
      step(8'(8'h20 + k), vpat[k]);
      check("gate_valid", {31'd0, s_valid}, {31'd0, vpat[k]});
      check("gate_data", {24'd0, s_data}, {24'd0, GOLD[8'h20 + k]});
    end

    // 32-bit tau on four lanes
    tau_in     = 32'h00010203;
    tau_vld_in = 1'b1;
    step(8'h00, 1'b0);
    check("tau_data", tau_out, 32'hD690E9FE);
    check("tau_valid", {28'd0, tau_vld_out}, 32'hF);
    tau_vld_in = 1'b0;
    step(8'h00, 1'b0);
    check("tau_valid_drop", {28'd0, tau_vld_out}, 32'h0);

    // Asynchronous reset mid-stream clears outputs before the next edge
    step(8'h11, 1'b1);
    check("pre_rst_data", {24'd0, s_data}, 32'h67);
    #2 rst = 1'b1;
    #1;
    check("async_rst_data", {24'd0, s_data}, 32'h0);
    check("async_rst_valid", {31'd0, s_valid}, 32'h0);
    step(8'hFF, 1'b1);
    check("rst_hold_data", {24'd0, s_data}, 32'h0);
    rst = 1'b0;
    step(8'h10, 1'b1);
    check("post_rst_data", {24'd0, s_data}, 32'h2B);
    check("post_rst_valid", {31'd0, s_valid}, 32'd1);
    step(8'h00, 1'b0);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sm4_sbox.md
# sm4_sbox

Registered SM4 S-box, one byte wide. It applies the fixed 8-bit SM4 non-linear substitution τ to one byte per cycle, with one clock of latency. Four instances in parallel form the 32-bit τ transform of the SM4 key-expansion and round datapaths. A valid flag travels alongside the data, so downstream stages can align on `o_s_valid`.

## Interface
Parameters: none. The substitution table is fixed by the SM4 standard (GB/T 32907-2016).

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset, asynchronous, active-high; clock is i_clk.
- i_data  input  8  byte to substitute.
- i_valid  input  1  qualifies i_data.
- o_s_data  output  8  S(i_data) registered; reset value 8'h00.
- o_s_valid  output  1  i_valid delayed one cycle; reset value 0.

## Operation
- `o_s_data` on the next rising edge is SBOX[i_data].
  - SBOX is the 256-entry SM4 table.
  - Index = i_data, with row = i_data[7:4] and column = i_data[3:0].
- The data register loads on every clock edge, independent of i_valid.
  - Consumers qualify the data with o_s_valid.
  - The parent feeds data continuously, so no hold or enable is provided.
- `o_s_valid` equals i_valid registered, with no other conditioning.
- No back-pressure. The block accepts one byte every cycle, back-to-back.
- The block is purely a lookup. It has no state machine and no arithmetic.
- Table anchor values:
  - S(00)=D6, S(01)=90, S(02)=E9, S(03)=FE, S(0F)=05
  - S(10)=2B, S(11)=67
  - S(F0)=18, S(FE)=39, S(FF)=48

## Timing
- Latency is exactly 1 cycle: input sampled at edge N appears on the outputs after edge N.
- Data and valid have identical latency and are always aligned.
- Throughput: 1 byte/cycle.
- Reset asserted (asynchronous): o_s_data=00 and o_s_valid=0 immediately, held while i_rst=1.
- First edge after reset deassertion: the registers capture the current inputs normally.
- Reset mid-stream: any in-flight byte is discarded and o_s_valid drops at once. There is no recovery sequence.
- The lookup is combinational from the i_data pins into the output register. There is no input register.

## Structure
- Shared package `sm4_pkg`: the 256×8 SBOX constant array, plus a `sm4_sbox_f(byte)` function returning SBOX[byte].
  - The key-expansion and round-function blocks reuse them.
  - FK and CK constants live in the same package.
- The lookup is coded as a full 256-way case or a constant array. No $readmemh, no file dependency.
  - The table must synthesise to LUT/ROM logic.
- No sub-module: this block is itself the leaf that gets instantiated four times for the 32-bit τ.

## Test plan
- Reset: hold i_rst=1 with random inputs -> o_s_data=00, o_s_valid=0. Assert i_rst asynchronously mid-stream -> outputs clear before the next edge.
- Single lookups: apply i_data=00, 01, 10, FF, each with i_valid=1 -> one cycle later o_s_data = D6, 90, 2B, 48 respectively, with o_s_valid=1.
- Exhaustive sweep: drive 00..FF back-to-back with i_valid=1 -> each output equals the golden SM4 table entry one cycle later; the result sequence is a permutation of all 256 values.
- Valid gating: toggle i_valid 1,0,1,1,0 with changing data -> o_s_valid reproduces the pattern delayed by 1. o_s_data still updates on i_valid=0 cycles.
- 32-bit τ cross-check: four instances on 32'h00010203 -> 32'hD690E9FE one cycle later, valid aligned on all lanes.
